// File: rtl/jk_bank_sequencer.sv
// Sequences an external bank of W JK flops as a loadable up/down counter via a req/ack handshake.
// Optional macro JKSEQ_SATURATE_EN: counts stop early at all-ones/all-zeros and output_SAT flags it.
module jk_bank_sequencer #(
  parameter int unsigned W  = 4,
  parameter int unsigned SW = 8
) (
  input  logic          input_CLK,
  input  logic          input_ENA,
  input  logic          input_REQ,
  input  logic [1:0]    input_OP,
  input  logic [W-1:0]  input_DATA,
  input  logic [SW-1:0] input_STEPS,
  input  logic [W-1:0]  input_Q,
  output logic [W-1:0]  output_J,
  output logic [W-1:0]  output_K,
  output logic          output_BUSY,
`ifdef JKSEQ_SATURATE_EN
  output logic          output_SAT,
`endif
  output logic          output_ACK
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  localparam logic [1:0] OpLoad  = 2'b00;
  localparam logic [1:0] OpClear = 2'b01;
  localparam logic [1:0] OpUp    = 2'b10;
  localparam logic [1:0] OpDn    = 2'b11;

  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [W-1:0]  data_q, data_d;
  logic [SW-1:0] steps_q, steps_d;
  logic [W-1:0]  toggle;

`ifdef JKSEQ_SATURATE_EN
  logic sat_q, sat_d;
  logic at_limit;
  assign at_limit = op_q[0] ? (input_Q == '0) : (input_Q == '1);
`endif

  // Bit i toggles when every lower bit is 1 (up) or 0 (down); bit 0 always toggles.
  always_comb begin : toggle_mask
    logic run;
    run    = 1'b1;
    toggle = '0;
    for (int i = 0; i < W; i++) begin
      toggle[i] = run;
      run       = run & (op_q[0] ? ~input_Q[i] : input_Q[i]);
    end
  end

  always_ff @(posedge input_CLK or posedge input_ENA) begin
    if (input_ENA) begin
      state_q <= StIdle;
      op_q    <= '0;
      data_q  <= '0;
      steps_q <= '0;
`ifdef JKSEQ_SATURATE_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      steps_q <= steps_d;
`ifdef JKSEQ_SATURATE_EN
      sat_q   <= sat_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    steps_d = steps_q;
`ifdef JKSEQ_SATURATE_EN
    sat_d   = sat_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (input_REQ) begin
          op_d    = input_OP;
          data_d  = input_DATA;
          steps_d = input_STEPS;
`ifdef JKSEQ_SATURATE_EN
          sat_d   = 1'b0;
`endif
          state_d = (input_OP[1] && (input_STEPS == '0)) ? StDone : StExec;
        end
      end
      StExec: begin
        if (!op_q[1]) begin
          state_d = StDone;
        end else begin
`ifdef JKSEQ_SATURATE_EN
          if (at_limit) begin
            state_d = StDone;
            steps_d = '0;
            sat_d   = 1'b1;
          end else
`endif
          begin
            steps_d = steps_q - SW'(1);
            if (steps_q == SW'(1)) state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    output_J = '0;
    output_K = '0;
    if (state_q == StExec) begin
      case (op_q)
        OpLoad: begin
          output_J = data_q;
          output_K = ~data_q;
        end
        OpClear: output_K = '1;
        OpUp, OpDn: begin
`ifdef JKSEQ_SATURATE_EN
          if (!at_limit) begin
            output_J = toggle;
            output_K = toggle;
          end
`else
          output_J = toggle;
          output_K = toggle;
`endif
        end
        default: ;
      endcase
    end
  end

  assign output_BUSY = (state_q != StIdle);
  assign output_ACK  = (state_q == StDone);
`ifdef JKSEQ_SATURATE_EN
  assign output_SAT  = (state_q == StDone) & sat_q;
`endif

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Randomized bench for jk_bank_sequencer: models the JK bank and predicts counter values arithmetically.
module tb_jk_bank_sequencer;
  localparam int unsigned W  = 4;
  localparam int unsigned SW = 8;

  logic          clk = 1'b0;
  logic          ena;
  logic          req;
  logic [1:0]    op;
  logic [W-1:0]  data;
  logic [SW-1:0] steps;
  logic [W-1:0]  bank_q = '0;
  logic [W-1:0]  j, k;
  logic          busy, ack;

  int n_checks = 0;
  int n_fail   = 0;

  jk_bank_sequencer #(.W(W), .SW(SW)) u_dut (
    .input_CLK   (clk),
    .input_ENA   (ena),
    .input_REQ   (req),
    .input_OP    (op),
    .input_DATA  (data),
    .input_STEPS (steps),
    .input_Q     (bank_q),
    .output_J    (j),
    .output_K    (k),
    .output_BUSY (busy),
    .output_ACK  (ack)
  );

  always #5 clk = ~clk;

  // External JK bank.
  always @(posedge clk) bank_q <= (j & ~bank_q) | (~k & bank_q);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One execute cycle of a command, from the counter's point of view.
  function automatic void step_model(input logic [1:0] c_op, input logic [W-1:0] d,
                                     input logic [W-1:0] q, output logic [W-1:0] ej,
                                     output logic [W-1:0] ek, output logic [W-1:0] nq);
    case (c_op)
      2'b00: begin ej = d;  ek = ~d; nq = d;  end
      2'b01: begin ej = '0; ek = '1; nq = '0; end
      2'b10: begin nq = q + W'(1); ej = nq ^ q; ek = ej; end
      default: begin nq = q - W'(1); ej = nq ^ q; ek = ej; end
    endcase
  endfunction

  task automatic run_cmd(input logic [1:0] c_op, input logic [W-1:0] c_data, input int c_steps,
                         input bit scramble);
    logic [W-1:0] q_exp, ej, ek, nq;
    int n_exec, cyc;
    bit got_ack;
    q_exp  = bank_q;
    n_exec = c_op[1] ? c_steps : 1;
    @(negedge clk);
    check_eq("idle_busy", 32'(busy), 0);
    req = 1'b1; op = c_op; data = c_data; steps = SW'(c_steps);
    @(posedge clk);
    cyc = 0;
    got_ack = 1'b0;
    while (!got_ack && cyc <= n_exec + 2) begin
      @(negedge clk);
      check_eq("q_seq", 32'(bank_q), 32'(q_exp));
      if (ack) begin
        got_ack = 1'b1;
      end else begin
        step_model(c_op, c_data, q_exp, ej, ek, nq);
        check_eq("exec_busy", 32'(busy), 1);
        check_eq("exec_j", 32'(j), 32'(ej));
        check_eq("exec_k", 32'(k), 32'(ek));
        q_exp = nq;
        cyc++;
        if (scramble) begin
          op = 2'($urandom); data = W'($urandom); steps = SW'($urandom);
          if ($urandom_range(3) == 0) req = 1'b0;
        end
      end
    end
    req = 1'b0;
    check_eq("ack_seen", 32'(got_ack), 1);
    check_eq("exec_cycles", cyc, n_exec);
    check_eq("done_busy", 32'(busy), 1);
    check_eq("done_jk", 32'({j, k}), 0);
    @(negedge clk);
    check_eq("ack_pulse", 32'(ack), 0);
    check_eq("back_idle", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] q0;
    ena = 1'b1; req = 1'b0; op = '0; data = '0; steps = '0;
    #1;
    check_eq("rst_outputs", 32'({j, k, busy, ack}), 0);
    @(negedge clk); @(negedge clk);
    ena = 1'b0;

    run_cmd(2'b00, 4'b1010, 0, 1'b0);
    check_eq("load_1010", 32'(bank_q), 32'hA);
    run_cmd(2'b00, 4'b0110, 0, 1'b0);
    run_cmd(2'b10, '0, 3, 1'b0);
    check_eq("up3", 32'(bank_q), 32'h9);
    run_cmd(2'b00, 4'b0001, 0, 1'b0);
    run_cmd(2'b11, '0, 3, 1'b0);
    check_eq("dn3_wrap", 32'(bank_q), 32'hE);
    run_cmd(2'b10, '0, 0, 1'b0);
    check_eq("up0_hold", 32'(bank_q), 32'hE);

    // CLEAR with REQ held across ACK re-executes after one idle cycle.
    run_cmd(2'b00, 4'b1111, 0, 1'b0);
    @(negedge clk);
    req = 1'b1; op = 2'b01; data = '0; steps = '0;
    @(negedge clk);
    check_eq("clr_jk", 32'({j, k}), 32'h0F);
    @(negedge clk);
    check_eq("clr_ack1", 32'(ack), 1);
    check_eq("clr_q", 32'(bank_q), 0);
    @(negedge clk);
    check_eq("clr_gap", 32'({busy, ack}), 0);
    @(negedge clk);
    check_eq("clr_again", 32'({busy, k}), 32'h1F);
    @(negedge clk);
    check_eq("clr_ack2", 32'(ack), 1);
    req = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a count.
    q0 = bank_q;
    @(negedge clk);
    req = 1'b1; op = 2'b10; steps = SW'(5);
    @(posedge clk);
    @(negedge clk);
    check_eq("pre_rst_busy", 32'(busy), 1);
    @(posedge clk);
    #2 ena = 1'b1;
    #1;
    check_eq("rst_async", 32'({j, k, busy, ack}), 0);
    req = 1'b0;
    @(negedge clk); @(negedge clk);
    check_eq("rst_bank_held", 32'(bank_q), 32'(q0 + W'(1)));
    check_eq("rst_no_ack", 32'({busy, ack}), 0);
    ena = 1'b0;

    for (int n = 0; n < 40; n++) begin
      run_cmd(2'($urandom), W'($urandom), int'($urandom_range(0, 6)), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
